axi_chan_fifo: RTL and testbench

- Parametrised valid/ready FIFO for one AXI channel payload (AW/W/B/AR/R), sized from the shared channel-width constants.
- Replaces fixed single-register channel slices with a DEPTH-entry buffer.
- Adds optional LAST-aware store-and-forward mode for burst channels (W, R) under AXI_FULL.
- Sits between the master/slave channel logic and the interconnect; one instance per channel.

---
 rtl/axi_helper_pkg.sv | 56 +++++
 rtl/axi_fifo_mem.sv | 25 ++
 rtl/axi_chan_fifo.sv | 110 +++++++++++
 tb/tb_axi_chan_fifo.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/axi_helper_pkg.sv
// rtl/axi_helper_pkg.sv - shared AXI channel widths, payload structs and sizing helpers
package axi_helper;

    localparam int ADDR_W    = 32;
    localparam int DATA_W    = 32;
    localparam int ID_W      = 4;
    localparam int STRB_LEN  = DATA_W / 8;
    localparam int WSTRB_LEN = STRB_LEN;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10
    } burst_e;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [ADDR_W-1:0] addr;
        logic [7:0]        len;
        logic [2:0]        size;
        burst_e            burst;
    } AxDATA_t;

    // last sits in the LSB of the burst-channel payloads
    typedef struct packed {
        logic [DATA_W-1:0]    data;
        logic [WSTRB_LEN-1:0] strb;
        logic                 last;
    } WxDATA_t;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [DATA_W-1:0] data;
        logic [1:0]        resp;
        logic              last;
    } RxDATA_t;

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [1:0]      resp;
    } BxDATA_t;

    localparam int AWxDATA_W = $bits(AxDATA_t);
    localparam int ARxDATA_W = $bits(AxDATA_t);
    localparam int WxDATA_W  = $bits(WxDATA_t);
    localparam int RxDATA_W  = $bits(RxDATA_t);
    localparam int BxDATA_W  = $bits(BxDATA_t);

    localparam int W_LAST_IDX = 0;
    localparam int R_LAST_IDX = 0;

    function automatic int cnt_w(input int depth);
        return (depth < 2) ? 2 : $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/axi_fifo_mem.sv
// rtl/axi_fifo_mem.sv - DEPTH x WIDTH register array, one write port, one async read port
module axi_fifo_mem #(
    parameter int WIDTH = 66,
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/axi_chan_fifo.sv
// rtl/axi_chan_fifo.sv - valid/ready channel FIFO with optional LAST-aware store-and-forward
module axi_chan_fifo
    import axi_helper::*;
#(
    parameter int WIDTH    = 66,
    parameter int DEPTH    = 4,
    parameter int LAST_EN  = 0,
    parameter int LAST_IDX = 0,
    parameter int PKT_MODE = 0
) (
    input  logic                       ACLK,
    input  logic                       ARESET,
    input  logic                       flush,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic [WIDTH-1:0]           s_data,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [WIDTH-1:0]           m_data,
    output logic [cnt_w(DEPTH)-1:0]    count,
    output logic [cnt_w(DEPTH)-1:0]    pkt_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = cnt_w(DEPTH);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count_q, count_nxt, pkt_q, pkt_nxt;
    logic          s_ready_q, draining, draining_nxt;
    logic          push, pop, s_last, m_last;

    assign push   = s_valid & s_ready_q;
    assign pop    = m_valid & m_ready;
    assign s_last = (LAST_EN != 0) ? s_data[LAST_IDX] : 1'b0;
    assign m_last = (LAST_EN != 0) ? m_data[LAST_IDX] : 1'b0;

    axi_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (ACLK),
        .we    (push & ~flush),
        .waddr (wr_ptr),
        .wdata (s_data),
        .raddr (rd_ptr),
        .rdata (m_data)
    );

    // A full FIFO with no complete packet must cut through, and keep going
    // until that packet's LAST leaves, or the source would deadlock.
    always_comb begin
        if (PKT_MODE != 0) begin
            m_valid = (count_q != '0) & ((pkt_q != '0) | (count_q == FULL) | draining);
        end else begin
            m_valid = (count_q != '0);
        end
    end

    always_comb begin
        count_nxt = count_q;
        case ({push, pop})
            2'b10:   count_nxt = count_q + 1'b1;
            2'b01:   count_nxt = count_q - 1'b1;
            default: count_nxt = count_q;
        endcase
        pkt_nxt = pkt_q;
        case ({push & s_last, pop & m_last})
            2'b10:   pkt_nxt = pkt_q + 1'b1;
            2'b01:   pkt_nxt = pkt_q - 1'b1;
            default: pkt_nxt = pkt_q;
        endcase
        draining_nxt = (draining | ((count_q == FULL) & (pkt_q == '0))) & ~(pop & m_last);
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count_q   <= '0;
            pkt_q     <= '0;
            draining  <= 1'b0;
            s_ready_q <= 1'b0;
        end else if (flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count_q   <= '0;
            pkt_q     <= '0;
            draining  <= 1'b0;
            s_ready_q <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count_q   <= count_nxt;
            pkt_q     <= pkt_nxt;
            draining  <= draining_nxt;
            s_ready_q <= (count_nxt < FULL);
        end
    end

    assign s_ready   = s_ready_q;
    assign count     = count_q;
    assign pkt_count = pkt_q;

endmodule

// File: tb/tb_axi_chan_fifo.sv
// tb/tb_axi_chan_fifo.sv - scoreboard bench for axi_chan_fifo in normal and packet mode
module tb_axi_chan_fifo;

    localparam int DEPTH = 4;
    localparam int W     = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         flush = 1'b0;
    logic         sv = 1'b0;
    logic [W-1:0] sd = '0;
    logic         mr = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic         s_ready, m_valid;
        logic [W-1:0] m_data;
        logic [2:0]   count, pkt_count;

        axi_chan_fifo #(
            .WIDTH    (W),
            .DEPTH    (DEPTH),
            .LAST_EN  (1),
            .LAST_IDX (0),
            .PKT_MODE (g)
        ) u_dut (
            .ACLK      (clk),
            .ARESET    (rst),
            .flush     (flush),
            .s_valid   (sv),
            .s_ready   (s_ready),
            .s_data    (sd),
            .m_valid   (m_valid),
            .m_ready   (mr),
            .m_data    (m_data),
            .count     (count),
            .pkt_count (pkt_count)
        );

        // Reference: a queue of beats; a packet is complete when its LAST beat is queued
        logic [W-1:0] q[$];
        bit           srdy_e = 1'b0;
        bit           drain_e = 1'b0;
        int           n, np;
        bit           mv_e, push, pop, head_last;
        logic [W-1:0] exp_beat;

        always @(negedge clk) begin
            n  = q.size();
            np = 0;
            foreach (q[i]) begin
                if (q[i][0]) np++;
            end
            if (rst) begin
                q.delete();
                srdy_e  = 1'b0;
                drain_e = 1'b0;
                chk($sformatf("d%0d_rst_s_ready", g), int'(s_ready), 0);
                chk($sformatf("d%0d_rst_m_valid", g), int'(m_valid), 0);
                chk($sformatf("d%0d_rst_count", g), int'(count), 0);
            end else begin
                if (g == 1) mv_e = (n > 0) && (np > 0 || n == DEPTH || drain_e);
                else        mv_e = (n > 0);
                chk($sformatf("d%0d_s_ready", g), int'(s_ready), int'(srdy_e));
                chk($sformatf("d%0d_m_valid", g), int'(m_valid), int'(mv_e));
                chk($sformatf("d%0d_count", g), int'(count), n);
                chk($sformatf("d%0d_pkt_count", g), int'(pkt_count), np);
                if (flush) begin
                    q.delete();
                    srdy_e  = 1'b1;
                    drain_e = 1'b0;
                end else begin
                    push      = sv && srdy_e;
                    pop       = mv_e && mr;
                    head_last = (n > 0) && q[0][0];
                    drain_e   = (drain_e || (n == DEPTH && np == 0)) && !(pop && head_last);
                    if (pop) begin
                        exp_beat = q.pop_front();
                        chk($sformatf("d%0d_m_data", g), int'(m_data), int'(exp_beat));
                    end
                    if (push) q.push_back(sd);
                    srdy_e = (q.size() < DEPTH);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        sv    = 1'b0;
        tick();
        flush = 1'b0;
    endtask

    initial begin
        #1 rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        chk("rel_s_ready_low", int'(g_dut[0].s_ready), 0);
        tick();
        chk("rel_s_ready_high", int'(g_dut[0].s_ready), 1);
        chk("rel_m_valid", int'(g_dut[0].m_valid), 0);

        // fill then drain, no LAST
        mr = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            sv = 1'b1;
            sd = W'(i << 1);
            tick();
        end
        sv = 1'b0;
        chk("fill_count", int'(g_dut[0].count), 4);
        chk("fill_s_ready", int'(g_dut[0].s_ready), 0);
        mr = 1'b1;
        repeat (6) tick();
        chk("drain_count", int'(g_dut[0].count), 0);
        mr = 1'b0;
        do_flush();

        // steady streaming at count=2 across pointer wrap
        for (int i = 0; i < 2; i++) begin
            sv = 1'b1;
            sd = W'(8'h20 + (i << 1));
            tick();
        end
        mr = 1'b1;
        for (int i = 2; i < 12; i++) begin
            sd = W'(8'h20 + (i << 1));
            tick();
        end
        chk("stream_count", int'(g_dut[0].count), 2);
        sv = 1'b0;
        repeat (4) tick();
        mr = 1'b0;
        do_flush();

        // store-and-forward: LAST on third beat
        sv = 1'b1; sd = 8'h10; tick();
        chk("sf_mv_b1", int'(g_dut[1].m_valid), 0);
        sd = 8'h12; tick();
        chk("sf_mv_b2", int'(g_dut[1].m_valid), 0);
        sd = 8'h15; tick();
        sv = 1'b0;
        chk("sf_mv_b3", int'(g_dut[1].m_valid), 1);
        chk("sf_pkt", int'(g_dut[1].pkt_count), 1);
        mr = 1'b1;
        repeat (4) tick();
        chk("sf_pkt_done", int'(g_dut[1].pkt_count), 0);
        mr = 1'b0;
        do_flush();

        // overflow cut-through: 6-beat packet
        mr = 1'b1;
        for (int i = 0; i < 6; i++) begin
            sv = 1'b1;
            sd = W'(8'h40 + (i << 1) + ((i == 5) ? 1 : 0));
            tick();
            while (!g_dut[1].s_ready && !g_dut[0].s_ready) tick();
        end
        sv = 1'b0;
        repeat (8) tick();
        chk("ct_count", int'(g_dut[1].count), 0);
        mr = 1'b0;

        // flush with full FIFO and a coincident beat
        for (int i = 0; i < 4; i++) begin
            sv = 1'b1;
            sd = W'(8'h61 + (i << 1));
            tick();
        end
        flush = 1'b1; sv = 1'b1; sd = 8'h7F;
        tick();
        flush = 1'b0; sv = 1'b0;
        for (int d = 0; d < 2; d++) begin
            chk("fl_count",   (d == 0) ? int'(g_dut[0].count)     : int'(g_dut[1].count), 0);
            chk("fl_pkt",     (d == 0) ? int'(g_dut[0].pkt_count) : int'(g_dut[1].pkt_count), 0);
            chk("fl_m_valid", (d == 0) ? int'(g_dut[0].m_valid)   : int'(g_dut[1].m_valid), 0);
            chk("fl_s_ready", (d == 0) ? int'(g_dut[0].s_ready)   : int'(g_dut[1].s_ready), 1);
        end

        // randomized traffic with occasional flush and one mid-stream reset
        for (int c = 0; c < 3000; c++) begin
            sv    = ($urandom_range(0, 3) != 0);
            sd    = W'($urandom);
            sd[0] = ($urandom_range(0, 4) == 0);
            mr    = ($urandom_range(0, 2) != 0);
            flush = ($urandom_range(0, 99) == 0);
            if (c == 1500) begin
                #3 rst = 1'b1;
                repeat (3) tick();
                rst = 1'b0;
            end else begin
                tick();
            end
        end
        sv = 1'b0; flush = 1'b0; mr = 1'b1;
        repeat (4) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
